// File: rtl/rv32i_pkg.sv
// Shared RV32I architectural widths.
package rv32i_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

endpackage : rv32i_pkg

// File: rtl/rv32i_regfile.sv
// RV32I integer register file: two combinational read ports, one normal
// write port and a debug read/write port sharing a single address.
// x0 has no storage and always reads zero. A normal write takes priority
// over a debug write at the same edge. Reset is synchronous and clears x1..x31.
module rv32i_regfile #(
    parameter int unsigned XLEN           = rv32i_pkg::XLEN,
    parameter int unsigned REG_ADDR_WIDTH = rv32i_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [XLEN-1:0]           rs1_data,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [XLEN-1:0]           rs2_data,

    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [XLEN-1:0]           rd_data,
    input  logic                      rd_we,

    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [XLEN-1:0]           dbg_wdata,
    input  logic                      dbg_we,
    output logic [XLEN-1:0]           dbg_rdata
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

    // Architectural storage for x1..x(NUM_REGS-1); x0 is never stored.
    logic [XLEN-1:0]           regs [1:NUM_REGS-1];

    // Read view with x0 hard-wired to zero, indexed directly by address.
    logic [XLEN-1:0]           rf_view [NUM_REGS];

    // Arbitrated write request for this cycle.
    logic                      wr_en_c;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_c;
    logic [XLEN-1:0]           wr_data_c;

    // One-hot write select per stored register.
    logic                      wr_sel_c [1:NUM_REGS-1];

    // Write arbitration: a normal write always wins, even to x0, which
    // means a concurrent debug write is dropped rather than deferred.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        if (rd_we) begin
            wr_en_c   = (rd_addr != '0);
            wr_addr_c = rd_addr;
            wr_data_c = rd_data;
        end else if (dbg_we) begin
            wr_en_c   = (dbg_addr != '0);
            wr_addr_c = dbg_addr;
            wr_data_c = dbg_wdata;
        end
    end

    // Decode the arbitrated address into per-register write enables.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            wr_sel_c[i] = wr_en_c && (wr_addr_c == REG_ADDR_WIDTH'(i));
        end
    end

    // Register storage: synchronous reset clears all entries and overrides writes.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rst) begin
                regs[i] <= '0;
            end else if (wr_sel_c[i]) begin
                regs[i] <= wr_data_c;
            end
        end
    end

    // Build the read view; no forwarding, so reads see committed contents only.
    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            rf_view[i] = regs[i];
        end
    end

    // Independent zero-latency read ports.
    always_comb begin
        rs1_data  = rf_view[rs1_addr];
        rs2_data  = rf_view[rs2_addr];
        dbg_rdata = rf_view[dbg_addr];
    end

endmodule : rv32i_regfile

// File: tb/tb_rv32i_regfile.sv
// Directed self-checking bench for rv32i_regfile.
module tb_rv32i_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_we;
    logic [31:0] dbg_rdata;

    int checks;
    int errors;

    rv32i_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_we     (rd_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_we    (dbg_we),
        .dbg_rdata (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rd_addr = a; rd_data = d; rd_we = 1'b1;
        tick();
        rd_we = 1'b0;
    endtask

    task automatic dwr(input logic [4:0] a, input logic [31:0] d);
        dbg_addr = a; dbg_wdata = d; dbg_we = 1'b1;
        tick();
        dbg_we = 1'b0;
    endtask

    task automatic rd1(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rs1_addr = a;
        #1;
        check(tag, rs1_data, exp);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        rs1_addr  = '0;
        rs2_addr  = '0;
        rd_addr   = '0;
        rd_data   = '0;
        rd_we     = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        dbg_we    = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        rd1(5'd5,  32'h0, "reset_x5");
        rd1(5'd31, 32'h0, "reset_x31");
        dbg_addr = 5'd7; #1;
        check("reset_dbg_x7", dbg_rdata, 32'h0);

        // x0 is never written
        wr(5'd0, 32'hDEADBEEF);
        dwr(5'd0, 32'hFFFFFFFF);
        rd1(5'd0, 32'h0, "x0_rs1");
        dbg_addr = 5'd0; #1;
        check("x0_dbg", dbg_rdata, 32'h0);

        // Basic writes and dual reads
        wr(5'd1,  32'h12345678);
        wr(5'd31, 32'hABCDEF00);
        wr(5'd10, 32'h11111111);
        wr(5'd11, 32'h22222222);
        rd1(5'd1,  32'h12345678, "basic_x1");
        rd1(5'd31, 32'hABCDEF00, "basic_x31");
        rs1_addr = 5'd10; rs2_addr = 5'd11; #1;
        check("dual_rs1_x10", rs1_data, 32'h11111111);
        check("dual_rs2_x11", rs2_data, 32'h22222222);
        rs2_addr = 5'd10; #1;
        check("same_rs1_x10", rs1_data, 32'h11111111);
        check("same_rs2_x10", rs2_data, 32'h11111111);

        // No forwarding: pending write not visible before the edge
        rd_addr = 5'd3; rd_data = 32'hAAAA5555; rd_we = 1'b1;
        rs1_addr = 5'd3; #1;
        check("nofwd_before", rs1_data, 32'h0);
        tick();
        rd_we = 1'b0;
        check("nofwd_after", rs1_data, 32'hAAAA5555);

        // Debug port
        wr(5'd15, 32'hDEADC0DE);
        dbg_addr = 5'd15; #1;
        check("dbg_read_x15", dbg_rdata, 32'hDEADC0DE);
        dwr(5'd20, 32'hCAFEBABE);
        rd1(5'd20, 32'hCAFEBABE, "dbg_write_x20");

        // All three read ports on the same register
        rs1_addr = 5'd15; rs2_addr = 5'd15; dbg_addr = 5'd15; #1;
        check("tri_rs1", rs1_data, 32'hDEADC0DE);
        check("tri_rs2", rs2_data, 32'hDEADC0DE);
        check("tri_dbg", dbg_rdata, 32'hDEADC0DE);

        // Priority: normal write wins, debug write dropped
        rd_addr = 5'd25; rd_data = 32'h11111111; rd_we = 1'b1;
        dbg_addr = 5'd25; dbg_wdata = 32'h22222222; dbg_we = 1'b1;
        tick();
        rd_we = 1'b0; dbg_we = 1'b0;
        rd1(5'd25, 32'h11111111, "prio_same_x25");
        rd_addr = 5'd25; rd_data = 32'h11111111; rd_we = 1'b1;
        dbg_addr = 5'd26; dbg_wdata = 32'h22222222; dbg_we = 1'b1;
        tick();
        rd_we = 1'b0; dbg_we = 1'b0;
        rd1(5'd26, 32'h0, "prio_diff_x26");
        // Normal write to x0 still blocks a concurrent debug write
        rd_addr = 5'd0; rd_data = 32'h0BADF00D; rd_we = 1'b1;
        dbg_addr = 5'd5; dbg_wdata = 32'h55555555; dbg_we = 1'b1;
        tick();
        rd_we = 1'b0; dbg_we = 1'b0;
        rd1(5'd5, 32'h0, "prio_x0_blocks_dbg");

        // Hold with no enables
        rd_addr = 5'd1; rd_data = 32'hFFFF0000;
        dbg_addr = 5'd1; dbg_wdata = 32'h0000FFFF;
        tick();
        tick();
        rd1(5'd1, 32'h12345678, "hold_x1");

        // Sweep all registers
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            rd1(5'(i), (i == 0) ? 32'h0 : 32'h1000 + 32'(i), $sformatf("sweep_x%0d", i));
        end
        rs2_addr = 5'd17; dbg_addr = 5'd30; #1;
        check("sweep_rs2_x17", rs2_data, 32'h1011);
        check("sweep_dbg_x30", dbg_rdata, 32'h101E);

        // Reset for 3 cycles, with a write attempted that reset must override
        rst = 1'b1;
        rd_addr = 5'd1; rd_data = 32'hFFFFFFFF; rd_we = 1'b1;
        dbg_addr = 5'd2; dbg_wdata = 32'hFFFFFFFF; dbg_we = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0; rd_we = 1'b0; dbg_we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            check($sformatf("rst_rs1_x%0d", i), rs1_data, 32'h0);
            check($sformatf("rst_rs2_x%0d", 31 - i), rs2_data, 32'h0);
            check($sformatf("rst_dbg_x%0d", i), dbg_rdata, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rv32i_regfile
